// File: rtl/ram_4002.sv
// rtl/ram_4002.sv - MCS-4 4002 RAM data chip model on the 4004 nibble bus
// Build option: RAM4002_OUTPUT_PORT_EN adds the WMP-driven port_o register.
module ram_4002 #(
  parameter logic [1:0] CHIP_ID = 2'd0
) (
  input  logic       eclk,
  input  logic       ereset,
  input  logic       clk1,
  input  logic       clk2,
  input  logic       sync,
  input  logic       cm_ram,
  input  logic [3:0] db_i,
  output logic [3:0] db_o,
  output logic       db_oe,
  output logic [3:0] port_o
);

  typedef enum logic [3:0] {
    PH_IDLE, PH_A1, PH_A2, PH_A3, PH_M1, PH_M2, PH_X1, PH_X2, PH_X3
  } phase_t;

  phase_t     phase;
  phase_t     phase_nxt;
  logic       clk2_q;
  logic       strobe;
  logic       selected;
  logic       src_half;
  logic [1:0] reg_sel;
  logic [3:0] char_sel;
  logic [3:0] opr;
  logic [3:0] opa;
  logic       io_cmd;
  logic       rd_en;
  logic [3:0] rd_data;
  logic [3:0] main_mem   [0:63];
  logic [3:0] status_mem [0:15];
  logic       unused_clk1;

  assign unused_clk1 = clk1;
  assign strobe      = clk2 & ~clk2_q;

  always_comb begin
    phase_nxt = PH_IDLE;
    if (sync) begin
      phase_nxt = PH_A1;
    end else begin
      case (phase)
        PH_A1:   phase_nxt = PH_A2;
        PH_A2:   phase_nxt = PH_A3;
        PH_A3:   phase_nxt = PH_M1;
        PH_M1:   phase_nxt = PH_M2;
        PH_M2:   phase_nxt = PH_X1;
        PH_X1:   phase_nxt = PH_X2;
        PH_X2:   phase_nxt = PH_X3;
        default: phase_nxt = PH_IDLE;
      endcase
    end
  end

  // Read data is presented for the whole X2 phase; db_oe/db_o register it.
  always_comb begin
    rd_en   = 1'b0;
    rd_data = 4'h0;
    if (phase == PH_X2 && io_cmd && selected) begin
      case (opa)
        4'h8, 4'h9, 4'hB: begin
          rd_en   = 1'b1;
          rd_data = main_mem[{reg_sel, char_sel}];
        end
        4'hC, 4'hD, 4'hE, 4'hF: begin
          rd_en   = 1'b1;
          rd_data = status_mem[{reg_sel, opa[1:0]}];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge eclk) begin
    if (ereset) begin
      phase    <= PH_IDLE;
      clk2_q   <= 1'b0;
      selected <= 1'b0;
      src_half <= 1'b0;
      reg_sel  <= 2'd0;
      char_sel <= 4'h0;
      opr      <= 4'h0;
      opa      <= 4'h0;
      io_cmd   <= 1'b0;
      db_o     <= 4'h0;
      db_oe    <= 1'b0;
      for (int i = 0; i < 64; i++) main_mem[i] <= 4'h0;
      for (int i = 0; i < 16; i++) status_mem[i] <= 4'h0;
    end else begin
      clk2_q <= clk2;
      db_oe  <= rd_en;
      db_o   <= rd_en ? rd_data : 4'h0;
      if (strobe) begin
        phase <= phase_nxt;
        case (phase)
          PH_M1: opr <= db_i;
          PH_M2: begin
            opa    <= db_i;
            io_cmd <= (opr == 4'hE) && cm_ram && selected;
          end
          PH_X2: begin
            // cm_ram during X2 marks the first half of an SRC address
            if (cm_ram) begin
              selected <= (db_i[3:2] == CHIP_ID);
              reg_sel  <= db_i[1:0];
              src_half <= 1'b1;
            end
            if (io_cmd && selected) begin
              if (opa == 4'h0) main_mem[{reg_sel, char_sel}] <= db_i;
              if (opa[3:2] == 2'b01) status_mem[{reg_sel, opa[1:0]}] <= db_i;
            end
          end
          PH_X3: begin
            if (src_half) char_sel <= db_i;
            src_half <= 1'b0;
            io_cmd   <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef RAM4002_OUTPUT_PORT_EN
  always_ff @(posedge eclk) begin
    if (ereset) begin
      port_o <= 4'h0;
    end else if (strobe && phase == PH_X2 && io_cmd && selected && opa == 4'h1) begin
      port_o <= db_i;
    end
  end
`else
  assign port_o = 4'h0;
`endif

endmodule

// File: tb/tb_ram_4002.sv
// tb/tb_ram_4002.sv - directed self-checking bench for ram_4002
module tb_ram_4002;

  logic       eclk = 1'b0;
  logic       ereset = 1'b1;
  logic       clk1 = 1'b0;
  logic       clk2 = 1'b0;
  logic       sync = 1'b0;
  logic       cm_ram = 1'b0;
  logic [3:0] db_i = 4'h0;
  logic [3:0] db_o;
  logic       db_oe;
  logic [3:0] port_o;

  int tests_run = 0;
  int tests_failed = 0;

  ram_4002 #(.CHIP_ID(2'd1)) dut (
    .eclk   (eclk),
    .ereset (ereset),
    .clk1   (clk1),
    .clk2   (clk2),
    .sync   (sync),
    .cm_ram (cm_ram),
    .db_i   (db_i),
    .db_o   (db_o),
    .db_oe  (db_oe),
    .port_o (port_o)
  );

  always #5 eclk = ~eclk;

  initial begin
    #400000;
    $display("FAIL watchdog: run did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One bus phase: drive inputs, sample outputs mid-phase, then strobe clk2.
  task automatic do_phase(input logic s, input logic cm, input logic [3:0] d,
                          output logic oe, output logic [3:0] dq);
    sync   = s;
    cm_ram = cm;
    db_i   = d;
    clk1   = 1'b1;
    @(negedge eclk);
    oe   = db_oe;
    dq   = db_o;
    clk1 = 1'b0;
    @(negedge eclk);
    clk2 = 1'b1;
    repeat (2) @(negedge eclk);
    clk2 = 1'b0;
  endtask

  task automatic instr(input logic [3:0] opr, input logic [3:0] opa,
                       input logic cm_m2, input logic cm_x2,
                       input logic [3:0] x2, input logic [3:0] x3,
                       output logic oe1, output logic oe2, output logic oe3,
                       output logic [3:0] d2);
    logic       unused_oe;
    logic [3:0] unused_d;
    do_phase(1'b0, 1'b0, 4'h0, unused_oe, unused_d);
    do_phase(1'b0, 1'b0, 4'h0, unused_oe, unused_d);
    do_phase(1'b0, 1'b0, 4'h0, unused_oe, unused_d);
    do_phase(1'b0, 1'b0, opr, unused_oe, unused_d);
    do_phase(1'b0, cm_m2, opa, unused_oe, unused_d);
    do_phase(1'b0, 1'b0, 4'h0, oe1, unused_d);
    do_phase(1'b0, cm_x2, x2, oe2, d2);
    do_phase(1'b1, 1'b0, x3, oe3, unused_d);
  endtask

  task automatic src(input logic [7:0] addr);
    logic       unused_o1, unused_o2, unused_o3;
    logic [3:0] unused_d;
    instr(4'h2, 4'h1, 1'b0, 1'b1, addr[7:4], addr[3:0],
          unused_o1, unused_o2, unused_o3, unused_d);
  endtask

  task automatic io(input logic [3:0] opa, input logic [3:0] data,
                    output logic oe1, output logic oe2, output logic oe3,
                    output logic [3:0] d2);
    instr(4'hE, opa, 1'b1, 1'b0, data, 4'h0, oe1, oe2, oe3, d2);
  endtask

  logic       o1, o2, o3;
  logic [3:0] d;
  logic [3:0] port_exp;

  initial begin
    repeat (3) @(negedge eclk);
    ereset = 1'b0;
    @(negedge eclk);
    check("reset_db_oe", {3'b000, db_oe}, 4'h0);
    check("reset_db_o", db_o, 4'h0);
    check("reset_port_o", port_o, 4'h0);

    do_phase(1'b1, 1'b0, 4'h0, o1, d);
    io(4'h9, 4'h0, o1, o2, o3, d);
    check("rdm_no_src_oe", {3'b000, o2}, 4'h0);

    src(8'h5A);
    io(4'h0, 4'h7, o1, o2, o3, d);
    io(4'h9, 4'h0, o1, o2, o3, d);
    check("rdm_x1_oe", {3'b000, o1}, 4'h0);
    check("rdm_x2_oe", {3'b000, o2}, 4'h1);
    check("rdm_x2_data", d, 4'h7);
    check("rdm_x3_oe", {3'b000, o3}, 4'h0);

    src(8'h70);
    io(4'h6, 4'hC, o1, o2, o3, d);
    io(4'hE, 4'h0, o1, o2, o3, d);
    check("rd2_oe", {3'b000, o2}, 4'h1);
    check("rd2_data", d, 4'hC);
    io(4'hC, 4'h0, o1, o2, o3, d);
    check("rd0_data", d, 4'h0);
    io(4'h8, 4'h0, o1, o2, o3, d);
    check("sbm_reg3_data", d, 4'h0);

    src(8'h5A);
    io(4'hE, 4'h0, o1, o2, o3, d);
    check("rd2_reg1_data", d, 4'h0);

    src(8'h9A);
    io(4'h0, 4'h3, o1, o2, o3, d);
    io(4'h9, 4'h0, o1, o2, o3, d);
    check("other_chip_oe", {3'b000, o2}, 4'h0);
    src(8'h5A);
    io(4'hB, 4'h0, o1, o2, o3, d);
    check("adm_after_other_oe", {3'b000, o2}, 4'h1);
    check("adm_after_other_data", d, 4'h7);

    io(4'h1, 4'h9, o1, o2, o3, d);
`ifdef RAM4002_OUTPUT_PORT_EN
    port_exp = 4'h9;
`else
    port_exp = 4'h0;
`endif
    check("wmp_port_o", port_o, port_exp);

    do_phase(1'b0, 1'b0, 4'h0, o1, d);
    do_phase(1'b0, 1'b0, 4'h0, o1, d);
    do_phase(1'b0, 1'b0, 4'h0, o1, d);
    do_phase(1'b0, 1'b0, 4'hE, o1, d);
    do_phase(1'b0, 1'b1, 4'h9, o1, d);
    ereset = 1'b1;
    repeat (2) @(negedge eclk);
    ereset = 1'b0;
    do_phase(1'b0, 1'b0, 4'h0, o1, d);
    do_phase(1'b0, 1'b0, 4'h0, o2, d);
    do_phase(1'b1, 1'b0, 4'h0, o3, d);
    check("midreset_x2_oe", {3'b000, o2}, 4'h0);
    check("midreset_x3_oe", {3'b000, o3}, 4'h0);
    check("midreset_port_o", port_o, 4'h0);

    src(8'h5A);
    io(4'h9, 4'h0, o1, o2, o3, d);
    check("post_reset_oe", {3'b000, o2}, 4'h1);
    check("post_reset_data", d, 4'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
